riscv_top: RTL and testbench

//  - RV32I integer core: multi-cycle FSM; top of the CPU, connects directly to external instruction/data memories.
//  - Instruction memory: synchronous, 1-cycle read; registers instr_in from imaddr_out on each clk_in rising edge.
//  - Data memory: synchronous, 1-cycle read; writes at the rising edge when dmwr_req_out=1.
//  - Not supported: interrupts, CSRs, exceptions.

---
 rtl/riscv_pkg.sv | 60 ++++++
 rtl/riscv_if.sv | 20 ++
 rtl/riscv_alu.sv | 35 +++
 rtl/riscv_top.sv | 226 ++++++++++++++++++++++
 tb/tb_riscv_top.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants, ALU operation and FSM state types.
package riscv_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // ALU funct3
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;

   // Branch funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Load/store funct3
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_FETCH, ST_EXEC, ST_LWB
   } state_t;

   // alt selects SUB/SRA (instruction bit 30)
   function automatic alu_op_t alu_op_decode(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/riscv_if.sv
// Instruction/data memory bus between the core (master) and memories (slave).
interface riscv_if;
   logic [31:0] instr_in;
   logic [31:0] imaddr_out;
   logic [31:0] dmdata_in;
   logic [31:0] dmaddr_out;
   logic [3:0]  dmwr_mask_out;
   logic        dmwr_req_out;
   logic [31:0] dmdata_out;

   modport master (
      input  instr_in, dmdata_in,
      output imaddr_out, dmaddr_out, dmwr_mask_out, dmwr_req_out, dmdata_out
   );

   modport slave (
      output instr_in, dmdata_in,
      input  imaddr_out, dmaddr_out, dmwr_mask_out, dmwr_req_out, dmdata_out
   );
endinterface

// File: rtl/riscv_alu.sv
// Combinational RV32I ALU with branch-compare flags on the same operands.
module riscv_alu
   import riscv_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  alu_op_t     i_op,
   output logic [31:0] o_result,
   output logic        o_eq,
   output logic        o_lt,
   output logic        o_ltu
);

   assign o_eq  = (i_a == i_b);
   assign o_lt  = ($signed(i_a) < $signed(i_b));
   assign o_ltu = (i_a < i_b);

   // Result select by operation
   always_comb begin
      o_result = '0;
      case (i_op)
         ALU_ADD:  o_result = i_a + i_b;
         ALU_SUB:  o_result = i_a - i_b;
         ALU_SLL:  o_result = i_a << i_b[4:0];
         ALU_SLT:  o_result = {31'b0, o_lt};
         ALU_SLTU: o_result = {31'b0, o_ltu};
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_SRL:  o_result = i_a >> i_b[4:0];
         ALU_SRA:  o_result = $signed(i_a) >>> i_b[4:0];
         ALU_OR:   o_result = i_a | i_b;
         default:  o_result = i_a & i_b;
      endcase
   end

endmodule

// File: rtl/riscv_top.sv
// Multi-cycle RV32I core: FETCH -> EXEC -> (loads) LWB, direct memory bus.
module riscv_top
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic     clk_in,
   input  logic     rst_in,
   riscv_if.master  bus
);

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_regs [0:31];
   logic [31:0] r_ld_addr;
   logic [2:0]  r_ld_f3;
   logic [4:0]  r_ld_rd;

   logic [31:0] w_instr, w_rs1, w_rs2;
   logic [6:0]  w_opc;
   logic [4:0]  w_rd, w_rs1_idx, w_rs2_idx;
   logic [2:0]  w_f3;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [31:0] w_alu_a, w_alu_b, w_alu;
   alu_op_t     w_alu_op;
   logic        w_eq, w_lt, w_ltu, w_taken;
   logic        w_is_load, w_is_store, w_wb_en;
   logic [31:0] w_pc_seq, w_pc_nxt, w_wb_data;
   logic [3:0]  w_st_mask;
   logic [31:0] w_st_data, w_ld_data;
   logic [7:0]  w_ld_b;
   logic [15:0] w_ld_h;

   assign w_instr   = bus.instr_in;
   assign w_opc     = w_instr[6:0];
   assign w_rd      = w_instr[11:7];
   assign w_f3      = w_instr[14:12];
   assign w_rs1_idx = w_instr[19:15];
   assign w_rs2_idx = w_instr[24:20];

   assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
   assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
   assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
   assign w_imm_u = {w_instr[31:12], 12'b0};
   assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

   assign w_rs1 = (w_rs1_idx == 5'd0) ? '0 : r_regs[w_rs1_idx];
   assign w_rs2 = (w_rs2_idx == 5'd0) ? '0 : r_regs[w_rs2_idx];

   assign w_is_load  = (w_opc == OPC_LOAD);
   assign w_is_store = (w_opc == OPC_STORE);
   assign w_pc_seq   = r_pc + 32'd4;

   // ALU operand/operation select; loads/stores/JALR reuse the adder for rs1+imm
   always_comb begin
      w_alu_a  = w_rs1;
      w_alu_b  = w_imm_i;
      w_alu_op = ALU_ADD;
      case (w_opc)
         OPC_OP: begin
            w_alu_b  = w_rs2;
            w_alu_op = alu_op_decode(w_f3, w_instr[30]);
         end
         OPC_OP_IMM: w_alu_op = alu_op_decode(w_f3, (w_f3 == F3_SR) && w_instr[30]);
         OPC_LUI: begin
            w_alu_a = '0;
            w_alu_b = w_imm_u;
         end
         OPC_AUIPC: begin
            w_alu_a = r_pc;
            w_alu_b = w_imm_u;
         end
         OPC_STORE:  w_alu_b = w_imm_s;
         OPC_BRANCH: begin
            w_alu_b  = w_rs2;
            w_alu_op = ALU_SUB;
         end
         default: ;
      endcase
   end

   riscv_alu u_alu (
      .i_a      (w_alu_a),
      .i_b      (w_alu_b),
      .i_op     (w_alu_op),
      .o_result (w_alu),
      .o_eq     (w_eq),
      .o_lt     (w_lt),
      .o_ltu    (w_ltu)
   );

   // Branch condition and next-PC selection
   always_comb begin
      case (w_f3)
         F3_BEQ:  w_taken = w_eq;
         F3_BNE:  w_taken = !w_eq;
         F3_BLT:  w_taken = w_lt;
         F3_BGE:  w_taken = !w_lt;
         F3_BLTU: w_taken = w_ltu;
         F3_BGEU: w_taken = !w_ltu;
         default: w_taken = 1'b0;
      endcase
      w_pc_nxt = w_pc_seq;
      case (w_opc)
         OPC_JAL:    w_pc_nxt = r_pc + w_imm_j;
         OPC_JALR:   w_pc_nxt = {w_alu[31:1], 1'b0};
         OPC_BRANCH: if (w_taken) w_pc_nxt = r_pc + w_imm_b;
         default: ;
      endcase
   end

   // EXEC write-back enable and value
   always_comb begin
      w_wb_en   = (w_opc == OPC_LUI) || (w_opc == OPC_AUIPC) || (w_opc == OPC_JAL) ||
                  (w_opc == OPC_JALR) || (w_opc == OPC_OP) || (w_opc == OPC_OP_IMM);
      w_wb_data = ((w_opc == OPC_JAL) || (w_opc == OPC_JALR)) ? w_pc_seq : w_alu;
   end

   // Store lane alignment from effective address
   always_comb begin
      case (w_f3[1:0])
         2'b00: begin
            w_st_mask = 4'b0001 << w_alu[1:0];
            w_st_data = {24'b0, w_rs2[7:0]} << {w_alu[1:0], 3'b000};
         end
         2'b01: begin
            w_st_mask = 4'b0011 << {w_alu[1], 1'b0};
            w_st_data = {16'b0, w_rs2[15:0]} << {w_alu[1], 4'b0000};
         end
         default: begin
            w_st_mask = 4'b1111;
            w_st_data = w_rs2;
         end
      endcase
   end

   // Load lane select and extension using the address latched in EXEC
   always_comb begin
      case (r_ld_addr[1:0])
         2'd0:    w_ld_b = bus.dmdata_in[7:0];
         2'd1:    w_ld_b = bus.dmdata_in[15:8];
         2'd2:    w_ld_b = bus.dmdata_in[23:16];
         default: w_ld_b = bus.dmdata_in[31:24];
      endcase
      w_ld_h = r_ld_addr[1] ? bus.dmdata_in[31:16] : bus.dmdata_in[15:0];
      case (r_ld_f3)
         F3_LB:   w_ld_data = {{24{w_ld_b[7]}}, w_ld_b};
         F3_LH:   w_ld_data = {{16{w_ld_h[15]}}, w_ld_h};
         F3_LBU:  w_ld_data = {24'b0, w_ld_b};
         F3_LHU:  w_ld_data = {16'b0, w_ld_h};
         default: w_ld_data = bus.dmdata_in;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_in) begin
      if (rst_in) r_state <= ST_FETCH;
      else        r_state <= w_state_nxt;
   end

   // FSM next-state
   always_comb begin
      w_state_nxt = ST_FETCH;
      case (r_state)
         ST_FETCH: w_state_nxt = ST_EXEC;
         ST_EXEC:  w_state_nxt = w_is_load ? ST_LWB : ST_FETCH;
         default:  w_state_nxt = ST_FETCH;
      endcase
   end

   // FSM outputs; gated by rst_in so an aborted store never reaches memory
   always_comb begin
      bus.dmwr_req_out  = 1'b0;
      bus.dmwr_mask_out = '0;
      bus.dmaddr_out    = '0;
      bus.dmdata_out    = '0;
      if (!rst_in) begin
         case (r_state)
            ST_EXEC: begin
               if (w_is_store) begin
                  bus.dmwr_req_out  = 1'b1;
                  bus.dmwr_mask_out = w_st_mask;
                  bus.dmaddr_out    = w_alu;
                  bus.dmdata_out    = w_st_data;
               end else if (w_is_load) begin
                  bus.dmaddr_out = w_alu;
               end
            end
            ST_LWB:  bus.dmaddr_out = r_ld_addr;
            default: ;
         endcase
      end
   end

   assign bus.imaddr_out = r_pc;

   // PC, register file and load context updates
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_pc      <= RESET_PC;
         r_regs    <= '{default: '0};
         r_ld_addr <= '0;
         r_ld_f3   <= '0;
         r_ld_rd   <= '0;
      end else begin
         case (r_state)
            ST_EXEC: begin
               if (w_is_load) begin
                  r_ld_addr <= w_alu;
                  r_ld_f3   <= w_f3;
                  r_ld_rd   <= w_rd;
               end else begin
                  r_pc <= w_pc_nxt;
               end
               if (w_wb_en && (w_rd != 5'd0)) r_regs[w_rd] <= w_wb_data;
            end
            ST_LWB: begin
               if (r_ld_rd != 5'd0) r_regs[r_ld_rd] <= w_ld_data;
               r_pc <= w_pc_seq;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_top.sv
// Bench for riscv_top: memory models, store scoreboard, vector table, corner sequences.
module tb_riscv_top;

   localparam logic [31:0] JSELF = 32'h0000_006F;   // jal x0,0

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] data;
   } st_exp_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      int          sreg;
      logic [31:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [31:0] imem [0:63];
   logic [31:0] dmem [0:63];
   logic [31:0] prog [$];
   st_exp_t     sb_q [$];
   vec_t        vecs [$];

   riscv_if bus ();

   riscv_top #(.RESET_PC(32'h0000_0000)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   initial forever #5 clk = ~clk;

   // Synchronous 1-cycle-read memories
   always @(posedge clk) begin
      bus.instr_in  <= imem[bus.imaddr_out[7:2]];
      bus.dmdata_in <= dmem[bus.dmaddr_out[7:2]];
   end

   function automatic logic [31:0] lanes(input logic [3:0] m);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
      return r;
   endfunction

   // Store monitor: every write request must match the next scoreboard entry
   always @(negedge clk) begin : mon
      st_exp_t     e;
      logic [31:0] lm;
      if (bus.dmwr_req_out) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_store: addr=%h mask=%b data=%h, required no store",
                     bus.dmaddr_out, bus.dmwr_mask_out, bus.dmdata_out);
         end else begin
            e  = sb_q.pop_front();
            lm = lanes(e.mask);
            if (bus.dmaddr_out !== e.addr || bus.dmwr_mask_out !== e.mask ||
                (bus.dmdata_out & lm) !== (e.data & lm)) begin
               n_fail++;
               $display("FAIL store: got addr=%h mask=%b data=%h, required addr=%h mask=%b data=%h",
                        bus.dmaddr_out, bus.dmwr_mask_out, bus.dmdata_out, e.addr, e.mask, e.data);
            end
         end
      end
   end

   function automatic logic [31:0] r_op(int f7, int rs2, int rs1, int f3, int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction
   function automatic logic [31:0] i_op(int imm, int rs1, int f3, int rd, int opc);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
   endfunction
   function automatic logic [31:0] s_op(int imm, int rs2, int rs1, int f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] b_op(int imm, int rs2, int rs1, int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] u_op(int imm, int rd, int opc);
      return {imm[19:0], rd[4:0], opc[6:0]};
   endfunction
   function automatic logic [31:0] j_op(int imm, int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
   endfunction
   function automatic logic [31:0] addi(int rd, int rs1, int imm);
      return i_op(imm, rs1, 0, rd, 'h13);
   endfunction
   function automatic logic [31:0] sw(int rs2, int imm);
      return s_op(imm, rs2, 0, 2);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      st_exp_t e;
      e.addr = a; e.mask = m; e.data = d;
      sb_q.push_back(e);
   endtask

   task automatic expect_drained(input string name);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d expected stores missing, required 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic load_prog();
      for (int i = 0; i < 64; i++) imem[i] = JSELF;
      foreach (prog[i]) imem[i] = prog[i];
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic add_vec(input string n, input logic [31:0] ins, input int sreg, input logic [31:0] ex);
      vec_t v;
      v.name = n; v.instr = ins; v.sreg = sreg; v.exp = ex;
      vecs.push_back(v);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) dmem[i] = '0;
      dmem[0] = 32'h0000_00F0;
      dmem[1] = 32'h8234_0000;

      // Sequence 1: reset state, fetch stepping, SW and SH lanes
      prog = {addi(1, 0, 5), addi(2, 0, 7), r_op(0, 2, 1, 0, 3),
              s_op(8, 3, 0, 2), s_op(6, 1, 0, 1), JSELF};
      load_prog();
      push_exp(32'd8, 4'b1111, 32'd12);
      push_exp(32'd6, 4'b1100, 32'h0005_0000);
      do_reset();
      check("rst_imaddr", bus.imaddr_out, 32'h0);
      check("rst_req",    {31'b0, bus.dmwr_req_out}, 32'h0);
      check("rst_mask",   {28'b0, bus.dmwr_mask_out}, 32'h0);
      check("rst_dmaddr", bus.dmaddr_out, 32'h0);
      check("rst_dmdata", bus.dmdata_out, 32'h0);
      for (int i = 1; i <= 3; i++) begin
         repeat (2) @(posedge clk);
         #1 check("imaddr_step", bus.imaddr_out, 32'(4 * i));
      end
      repeat (12) @(posedge clk);
      expect_drained("seq1_stores");

      // Sequence 2: load extension and misaligned lane selection
      prog = {i_op(0, 0, 0, 4, 3), sw(4, 'h20),
              i_op(0, 0, 4, 5, 3), sw(5, 'h24),
              i_op(6, 0, 1, 6, 3), sw(6, 'h28),
              i_op(6, 0, 5, 7, 3), sw(7, 'h2C),
              i_op(7, 0, 0, 8, 3), sw(8, 'h30),
              i_op(4, 0, 2, 9, 3), sw(9, 'h34),
              s_op('h3D, 4, 0, 0), JSELF};
      load_prog();
      push_exp(32'h20, 4'b1111, 32'hFFFF_FFF0);
      push_exp(32'h24, 4'b1111, 32'h0000_00F0);
      push_exp(32'h28, 4'b1111, 32'hFFFF_8234);
      push_exp(32'h2C, 4'b1111, 32'h0000_8234);
      push_exp(32'h30, 4'b1111, 32'hFFFF_FF82);
      push_exp(32'h34, 4'b1111, 32'h8234_0000);
      push_exp(32'h3D, 4'b0010, 32'h0000_F000);
      do_reset();
      repeat (45) @(posedge clk);
      expect_drained("loads");

      // Sequence 3: reset pulsed during EXEC of a store aborts it
      prog = {addi(1, 0, 9), sw(1, 'h40), JSELF};
      load_prog();
      do_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1 check("abort_req",  {31'b0, bus.dmwr_req_out}, 32'h0);
      check("abort_mask", {28'b0, bus.dmwr_mask_out}, 32'h0);
      @(posedge clk);
      #1 check("abort_pc", bus.imaddr_out, 32'h0);
      rst = 1'b0;
      push_exp(32'h40, 4'b1111, 32'd9);
      repeat (10) @(posedge clk);
      expect_drained("abort_rerun");

      // Vector table: x10=-1 x11=5 x12=1 x13=8 x14=33, test at PC 20, taken path stores 77
      add_vec("add",   r_op(0, 11, 10, 0, 5),     5, 32'h0000_0004);
      add_vec("sub",   r_op('h20, 11, 12, 0, 5),  5, 32'hFFFF_FFFC);
      add_vec("sll",   r_op(0, 11, 11, 1, 5),     5, 32'h0000_00A0);
      add_vec("slt",   r_op(0, 12, 10, 2, 5),     5, 32'h0000_0001);
      add_vec("sltu",  r_op(0, 12, 10, 3, 5),     5, 32'h0000_0000);
      add_vec("xor",   r_op(0, 11, 10, 4, 5),     5, 32'hFFFF_FFFA);
      add_vec("srl",   r_op(0, 14, 10, 5, 5),     5, 32'h7FFF_FFFF);
      add_vec("sra",   r_op('h20, 11, 10, 5, 5),  5, 32'hFFFF_FFFF);
      add_vec("or",    r_op(0, 12, 11, 6, 5),     5, 32'h0000_0005);
      add_vec("and",   r_op(0, 11, 10, 7, 5),     5, 32'h0000_0005);
      add_vec("addi",  i_op(-16, 10, 0, 5, 'h13), 5, 32'hFFFF_FFEF);
      add_vec("slti",  i_op(0, 10, 2, 5, 'h13),   5, 32'h0000_0001);
      add_vec("sltiu", i_op(-1, 12, 3, 5, 'h13),  5, 32'h0000_0001);
      add_vec("xori",  i_op(-1, 11, 4, 5, 'h13),  5, 32'hFFFF_FFFA);
      add_vec("ori",   i_op('h10, 11, 6, 5, 'h13), 5, 32'h0000_0015);
      add_vec("andi",  i_op('h7F0, 10, 7, 5, 'h13), 5, 32'h0000_07F0);
      add_vec("slli",  i_op(31, 11, 1, 5, 'h13),  5, 32'h8000_0000);
      add_vec("srli",  i_op(28, 10, 5, 5, 'h13),  5, 32'h0000_000F);
      add_vec("srai",  i_op('h404, 10, 5, 5, 'h13), 5, 32'hFFFF_FFFF);
      add_vec("lui",   u_op('h12345, 5, 'h37),    5, 32'h1234_5000);
      add_vec("auipc", u_op(1, 5, 'h17),          5, 32'h0000_1014);
      add_vec("jal",   j_op(24, 5),               5, 32'd24);
      add_vec("jalr",  i_op(37, 13, 0, 5, 'h67),  5, 32'd24);
      add_vec("x0_wr", addi(0, 0, 1),             0, 32'h0);
      add_vec("fence", 32'h0000_000F,             5, 32'h0);
      add_vec("ecall", 32'h0000_0073,             5, 32'h0);
      add_vec("unk",   32'h0010_028B,             5, 32'h0);
      add_vec("blt",   b_op(20, 12, 10, 4),       5, 32'd77);
      add_vec("bltu",  b_op(20, 12, 10, 6),       5, 32'd0);
      add_vec("beq",   b_op(20, 11, 11, 0),       5, 32'd77);
      add_vec("bne_n", b_op(20, 11, 11, 1),       5, 32'd0);
      add_vec("bne_t", b_op(20, 12, 11, 1),       5, 32'd77);
      add_vec("bge_t", b_op(20, 10, 12, 5),       5, 32'd77);
      add_vec("bge_n", b_op(20, 12, 10, 5),       5, 32'd0);
      add_vec("bgeu_n", b_op(20, 10, 12, 7),      5, 32'd0);
      add_vec("bgeu_t", b_op(20, 12, 10, 7),      5, 32'd77);

      foreach (vecs[k]) begin
         prog = {addi(10, 0, -1), addi(11, 0, 5), addi(12, 0, 1), addi(13, 0, 8),
                 addi(14, 0, 33), vecs[k].instr, sw(vecs[k].sreg, 'h40), JSELF,
                 JSELF, JSELF, addi(5, 0, 77), sw(5, 'h40), JSELF};
         load_prog();
         push_exp(32'h40, 4'b1111, vecs[k].exp);
         do_reset();
         repeat (24) @(posedge clk);
         expect_drained(vecs[k].name);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
